// File: rtl/param_sync_ram.sv
// ---------------------------------------------------------------------------
// param_sync_ram
//
// Parametrised single-port synchronous data memory for the RISC datapath.
// Byte-enable writes, registered read data with a valid strobe, write-first
// behaviour when a read and a write hit the same address in the same cycle,
// an address-range check, and a clear sequencer that zeroes the whole array
// after reset or on request.
//
// Parameters:
//   DATA_WIDTH  word width in bits (multiple of 8)
//   ADDR_WIDTH  address port width in bits
//   DEPTH       number of implemented words (2 .. 2^ADDR_WIDTH)
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   addr      word address for read and write
//   wdata     write data
//   be        byte enables, bit i qualifies wdata[8i+7:8i]
//   we        write request
//   re        read request
//   clear     single-cycle request to zero the whole array
//   rdata     registered read data, holds between reads
//   rvalid    one-cycle pulse, rdata valid
//   addr_err  one-cycle pulse, accepted access had addr >= DEPTH
//   busy      clear sweep in progress, requests ignored
// ---------------------------------------------------------------------------
module param_sync_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic                    we,
    input  logic                    re,
    input  logic                    clear,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rvalid,
    output logic                    addr_err,
    output logic                    busy
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        STATE_CLEAR = 1'b0,
        STATE_READY = 1'b1
    } state_e;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_e                state_q, state_d;
    logic [PTR_W-1:0]      clr_ptr_q, clr_ptr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  addr_err_q, addr_err_d;
    logic                  busy_q;

    logic                  inRange;
    logic [PTR_W-1:0]      addrIdx;
    logic [DATA_WIDTH-1:0] oldWord;
    logic [DATA_WIDTH-1:0] mergedWord;
    logic                  memWe;
    logic [PTR_W-1:0]      memIdx;
    logic [DATA_WIDTH-1:0] memWdata;

    // The range check uses the full address, one bit wider so that
    // DEPTH == 2^ADDR_WIDTH compares correctly. Only the low bits index the
    // array, and only after the check has passed, so upper bits never alias.
    always_comb begin
        inRange = ({1'b0, addr} < (ADDR_WIDTH+1)'(DEPTH));
        addrIdx = addr[PTR_W-1:0];
        oldWord = '0;
        if (inRange) begin
            oldWord = mem[addrIdx];
        end
        mergedWord = oldWord;
        for (int b = 0; b < NB; b++) begin
            if (be[b]) begin
                mergedWord[8*b +: 8] = wdata[8*b +: 8];
            end
        end
    end

    // Next-state logic. The merged word feeds both the array write and the
    // read data so a same-address read sees the freshly written bytes.
    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
        addr_err_d = 1'b0;
        memWe      = 1'b0;
        memIdx     = clr_ptr_q;
        memWdata   = '0;

        unique case (state_q)
            STATE_CLEAR: begin
                memWe    = 1'b1;
                memIdx   = clr_ptr_q;
                memWdata = '0;
                if (clr_ptr_q == PTR_W'(DEPTH-1)) begin
                    state_d   = STATE_READY;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + PTR_W'(1);
                end
            end
            STATE_READY: begin
                if (clear) begin
                    state_d   = STATE_CLEAR;
                    clr_ptr_d = '0;
                end else begin
                    if ((we || re) && !inRange) begin
                        addr_err_d = 1'b1;
                    end
                    if (we && inRange) begin
                        memWe    = 1'b1;
                        memIdx   = addrIdx;
                        memWdata = mergedWord;
                    end
                    if (re) begin
                        rvalid_d = 1'b1;
                        if (!inRange) begin
                            rdata_d = '0;
                        end else if (we) begin
                            rdata_d = mergedWord;
                        end else begin
                            rdata_d = oldWord;
                        end
                    end
                end
            end
            default: begin
                state_d = STATE_CLEAR;
            end
        endcase
    end

    // Control and output registers. Reset forces a fresh sweep from entry 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= STATE_CLEAR;
            clr_ptr_q  <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            addr_err_q <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            addr_err_q <= addr_err_d;
            busy_q     <= (state_d == STATE_CLEAR);
        end
    end

    // Storage array has no reset; the clear sweep is what zeroes it.
    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[memIdx] <= memWdata;
        end
    end

    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign addr_err = addr_err_q;
    assign busy     = busy_q;

endmodule

// File: doc/param_sync_ram.md
Name: param_sync_ram

Overview:
- Parametrised, fully synchronous single-port data memory for the RISC datapath.
- Generalises the existing 16x16 data RAM: configurable width and depth, byte-enable writes, registered read with valid strobe, write-first read-during-write.
- Adds address-range checking and a hardware clear sequencer that zeroes the array after reset or on request.
- Sits between the load/store unit and the register file; no tristate output.

Parameters:
DATA_WIDTH, 16, word width in bits; must be a multiple of 8
ADDR_WIDTH, 16, address port width in bits
DEPTH, 16, number of implemented words; DEPTH <= 2^ADDR_WIDTH and DEPTH >= 2

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
addr  input  ADDR_WIDTH  word address for read and write
wdata  input  DATA_WIDTH  write data
be  input  DATA_WIDTH/8  byte enables; bit i qualifies wdata[8i+7:8i]
we  input  1  write request
re  input  1  read request
clear  input  1  single-cycle request to zero the whole array
rdata  output  DATA_WIDTH  registered read data; holds value between reads
rvalid  output  1  one-cycle pulse, rdata valid
addr_err  output  1  one-cycle pulse, accepted access had addr >= DEPTH
busy  output  1  clear sweep in progress; requests ignored

Behaviour:
- Reset (rst_n low, asynchronous): rdata=0, rvalid=0, addr_err=0, busy=1, state=CLEAR, clr_ptr=0. The array contents are not reset directly; the CLEAR sweep zeroes them.
- FSM states:
  - CLEAR: each cycle writes 0 to mem[clr_ptr] and increments clr_ptr. When clr_ptr==DEPTH-1, that entry is written and the next state is READY.
  - Timing: busy=1 for exactly DEPTH rising edges after rst_n deasserts, and is 0 from the first READY cycle. busy is registered and equals (state==CLEAR).
  - READY: services requests.
  - Transitions: `clear`=1 in READY moves to CLEAR with clr_ptr=0; busy rises the next cycle.
- In CLEAR:
  - we, re and clear are ignored; there is no restart of the sweep.
  - rvalid=0 and addr_err=0; rdata holds its value.
- Write (READY, we=1, addr<DEPTH): at the posedge, each byte i with be[i]=1 is updated; bytes with be[i]=0 are unchanged. be=0 is a legal no-op.
- Read (READY, re=1):
  - Latency 1: rdata and rvalid=1 appear on the edge after the request cycle.
  - rvalid is deasserted the following cycle unless re is held. Back-to-back reads give one word per cycle.
- Read-during-write, same address, same cycle: write-first. rdata returns the merged word (new bytes where be=1, old bytes elsewhere).
- Out-of-range (READY, addr>=DEPTH, re or we):
  - Any write is suppressed.
  - A read returns rdata=0 with rvalid=1.
  - addr_err=1 for one cycle, aligned with the rvalid slot, or the cycle after a write-only request.
- clear together with re/we in READY: clear wins. The access is dropped: no write, no rvalid.
- Reset asserted mid-sweep or mid-access: immediate return to reset values; the sweep restarts from 0 after release.
- Address bits above clog2(DEPTH) are used only for the range check, with no aliasing.

Test Plan:
- DEPTH=16: release rst_n -> busy=1 for exactly 16 cycles, then 0. Read addr 0..15 -> rdata=0x0000 each, rvalid one cycle after each re.
- Write 0xA5C3 to addr 3 with be=2'b11, then re at addr 3 -> next cycle rdata=0xA5C3, rvalid=1, addr_err=0.
- Then write 0x1234 to addr 3 with be=2'b01 -> read addr 3 gives 0xA534. Then be=2'b00 with 0xFFFF -> still 0xA534.
- Same-cycle we=1, re=1, addr 5, wdata 0xBEEF, be=2'b11 (old value 0x0000) -> next cycle rdata=0xBEEF. Repeat with be=2'b10 and wdata 0x1100 -> 0x11EF.
- DEPTH=12: write 0x7777 to addr 13 -> addr_err pulse, no array change. Read addr 13 -> rdata=0, rvalid=1, addr_err=1. Read addr 1 (13 mod 12) -> unchanged value.
- Pulse clear in READY after filling addr 0..15 with 0xFFFF -> busy high 16 cycles, re during sweep gives no rvalid, then all reads return 0. Asserting rst_n low at sweep cycle 7 -> busy stays 1 and a full 16-cycle sweep follows release.
